// File: rtl/pll_lock_sequencer.sv
// Reset/lock supervisor for the memory-test PLL: drives the PLL reset, qualifies lock,
// releases the downstream system reset once lock is stable, and retries or re-sequences.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 74250,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  localparam int unsigned MaxRl     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxCycles = (MaxRl > STABLE_CYCLES) ? MaxRl : STABLE_CYCLES;
  localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int unsigned RetryW    = $clog2(MAX_RETRIES + 1);

  localparam logic [TimerW-1:0] RstLast    = TimerW'(RST_CYCLES - 1);
  localparam logic [TimerW-1:0] LockLast   = TimerW'(LOCK_TIMEOUT - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax   = RetryW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StResetPll = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [RetryW-1:0]   retries_q, retries_d;
  logic [RetryW-1:0]   retries_inc;
  logic [7:0]          relock_q, relock_d;
  logic                sync1_q, sync2_q;
  logic                locked_s;
  logic                pll_rst_q, pll_rst_d;
  logic                sys_rst_q, sys_rst_d;
  logic                ready_q, ready_d;
  logic                fail_q, fail_d;

  // pll_locked is asynchronous to refclk; two flops before any decision uses it.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s    = sync2_q;
  assign retries_inc = retries_q + RetryW'(1);

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    relock_d  = relock_q;

    if (restart) begin
      state_d   = StResetPll;
      timer_d   = '0;
      retries_d = '0;
    end else begin
      case (state_q)
        StResetPll: begin
          if (timer_q == RstLast) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StWaitLock: begin
          if (locked_s) begin
            state_d = StStable;
            timer_d = '0;
          end else if (timer_q == LockLast) begin
            retries_d = retries_inc;
            timer_d   = '0;
            state_d   = (retries_inc == RetryMax) ? StFail : StResetPll;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StStable: begin
          // A lock drop here is chatter, not a failed attempt: no retry is consumed.
          if (!locked_s) begin
            state_d = StWaitLock;
            timer_d = '0;
          end else if (timer_q == StableLast) begin
            state_d   = StRun;
            timer_d   = '0;
            retries_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StRun: begin
          if (!locked_s) begin
            state_d = StResetPll;
            timer_d = '0;
            if (relock_q != 8'hFF) begin
              relock_d = relock_q + 8'd1;
            end
          end
        end
        StFail: begin
          state_d = StFail;
        end
        default: begin
          state_d = StResetPll;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the transition edge.
  always_comb begin
    pll_rst_d = (state_d == StResetPll);
    sys_rst_d = (state_d != StRun);
    ready_d   = (state_d == StRun);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= StResetPll;
      timer_q   <= '0;
      retries_q <= '0;
      relock_q  <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
      relock_q  <= relock_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_rst      = sys_rst_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign state        = state_q;
  assign relock_count = relock_q;

endmodule
